// File: rtl/tele_call_ctrl.sv
// tele_call_ctrl: single-line telephone call controller.
// Tracks one call through dialling (with automatic redial), talking,
// hold/resume and the two timeout states. All timers are internal.
// Every output is decoded from registered state and counters, so no
// input reaches an output combinationally.
//
// Input semantics: all request inputs are level-sampled on the rising
// edge and are only acted on in the states that listen to them; there
// is no valid/ready handshake, and a request held high in a state that
// ignores it has no effect and is not queued.

module tele_call_ctrl #(
  parameter int DIAL_LIMIT = 5,
  parameter int MAX_RETRY  = 2,
  parameter int CALL_LIMIT = 250,
  parameter int HOLD_LIMIT = 50,
  parameter int CNT_W      = 8,
  parameter int TOT_W      = 16,
  localparam int RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_cntct,
  input  logic             dial,
  input  logic             pickup_call,
  input  logic             cancel,
  input  logic             end_call,
  input  logic             hold_req,
  input  logic             resume_req,
  output logic [2:0]       state,
  output logic             dial_timeout,
  output logic             in_call,
  output logic             on_hold,
  output logic             call_timeout,
  output logic             call_done,
  output logic [1:0]       end_cause,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] call_time,
  output logic [TOT_W-1:0] calls_completed
);

  // Counter widths for the internal dial and hold timers.
  localparam int DCNT_W = (DIAL_LIMIT <= 2) ? 1 : $clog2(DIAL_LIMIT);
  localparam int HCNT_W = (HOLD_LIMIT <= 2) ? 1 : $clog2(HOLD_LIMIT);

  // State encodings (visible on the state output).
  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_DIAL         = 3'd1;
  localparam logic [2:0] S_DIAL_TIMEOUT = 3'd2;
  localparam logic [2:0] S_IN_CALL      = 3'd3;
  localparam logic [2:0] S_END_CALL     = 3'd4;
  localparam logic [2:0] S_CALL_TIMEOUT = 3'd5;
  localparam logic [2:0] S_HOLD         = 3'd6;

  // End-cause codes.
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LOCAL = 2'd1;
  localparam logic [1:0] CAUSE_HOLD  = 2'd2;

  // Terminal counts, pre-sized to the counters they are compared with.
  localparam logic [DCNT_W-1:0] DIAL_LAST = DCNT_W'(DIAL_LIMIT - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_LIMIT - 1);
  localparam logic [CNT_W-1:0]  CALL_LAST = CNT_W'(CALL_LIMIT - 1);
  localparam logic [RTY_W-1:0]  RETRY_MAX = RTY_W'(MAX_RETRY);

  logic [2:0]        state_q,           state_d;
  logic [DCNT_W-1:0] dial_cnt_q,        dial_cnt_d;
  logic [RTY_W-1:0]  retry_cnt_q,       retry_cnt_d;
  logic [CNT_W-1:0]  call_time_q,       call_time_d;
  logic [HCNT_W-1:0] hold_cnt_q,        hold_cnt_d;
  logic [1:0]        end_cause_q,       end_cause_d;
  logic [TOT_W-1:0]  calls_completed_q, calls_completed_d;

  // Next-state and counter update: transitions in priority order per state.
  always_comb begin
    state_d           = state_q;
    dial_cnt_d        = dial_cnt_q;
    retry_cnt_d       = retry_cnt_q;
    call_time_d       = call_time_q;
    hold_cnt_d        = hold_cnt_q;
    end_cause_d       = CAUSE_NONE;
    calls_completed_d = calls_completed_q;

    case (state_q)
      S_IDLE: begin
        if (dial && valid_cntct) begin
          state_d     = S_DIAL;
          dial_cnt_d  = '0;
          retry_cnt_d = '0;
          call_time_d = '0;
        end
      end

      S_DIAL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (pickup_call) begin
          state_d     = S_IN_CALL;
          call_time_d = '0;
        end else if (dial_cnt_q == DIAL_LAST) begin
          // Attempt expired: redial while retries remain, else give up.
          if (retry_cnt_q < RETRY_MAX) begin
            dial_cnt_d  = '0;
            retry_cnt_d = retry_cnt_q + 1'b1;
          end else begin
            state_d = S_DIAL_TIMEOUT;
          end
        end else begin
          dial_cnt_d = dial_cnt_q + 1'b1;
        end
      end

      S_DIAL_TIMEOUT: begin
        if (cancel) state_d = S_IDLE;
      end

      S_IN_CALL: begin
        // Talk time advances on every IN_CALL edge, including the exit edge,
        // so a timeout leaves call_time at exactly CALL_LIMIT.
        call_time_d = call_time_q + 1'b1;
        if (end_call) begin
          state_d     = S_END_CALL;
          end_cause_d = CAUSE_LOCAL;
        end else if (hold_req) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else if (call_time_q == CALL_LAST) begin
          state_d = S_CALL_TIMEOUT;
        end
      end

      S_HOLD: begin
        // call_time is frozen while held; only the hold timer runs.
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (end_call) begin
          state_d     = S_END_CALL;
          end_cause_d = CAUSE_LOCAL;
        end else if (resume_req) begin
          state_d = S_IN_CALL;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = S_END_CALL;
          end_cause_d = CAUSE_HOLD;
        end
      end

      S_END_CALL: begin
        state_d = S_IDLE;
        if (calls_completed_q != '1) calls_completed_d = calls_completed_q + 1'b1;
      end

      S_CALL_TIMEOUT: begin
        if (cancel) state_d = S_IDLE;
      end

      default: begin
        // Illegal encoding: recover to IDLE with every counter cleared.
        state_d           = S_IDLE;
        dial_cnt_d        = '0;
        hold_cnt_d        = '0;
        calls_completed_d = '0;
      end
    endcase

    // Per-call counters always read zero while idle.
    if (state_d == S_IDLE) begin
      retry_cnt_d = '0;
      call_time_d = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      dial_cnt_q        <= '0;
      retry_cnt_q       <= '0;
      call_time_q       <= '0;
      hold_cnt_q        <= '0;
      end_cause_q       <= CAUSE_NONE;
      calls_completed_q <= '0;
    end else begin
      state_q           <= state_d;
      dial_cnt_q        <= dial_cnt_d;
      retry_cnt_q       <= retry_cnt_d;
      call_time_q       <= call_time_d;
      hold_cnt_q        <= hold_cnt_d;
      end_cause_q       <= end_cause_d;
      calls_completed_q <= calls_completed_d;
    end
  end

  // Moore output decode from registered state and counters.
  always_comb begin
    state           = state_q;
    dial_timeout    = (state_q == S_DIAL_TIMEOUT);
    in_call         = (state_q == S_IN_CALL);
    on_hold         = (state_q == S_HOLD);
    call_timeout    = (state_q == S_CALL_TIMEOUT);
    call_done       = (state_q == S_END_CALL);
    end_cause       = end_cause_q;
    retry_cnt       = retry_cnt_q;
    call_time       = call_time_q;
    calls_completed = calls_completed_q;
  end

endmodule

// File: tb/tb_tele_call_ctrl.sv
// Bench for tele_call_ctrl. Two instances share one stimulus stream: the
// default configuration and a TOT_W=2 copy whose completed-call counter
// saturates early. A reference model written in terms of elapsed time per
// phase predicts every output for the next cycle; a separate monitor pops
// and compares once per cycle.

module tb_tele_call_ctrl;

  localparam int DIAL_LIMIT = 5;
  localparam int MAX_RETRY  = 2;
  localparam int CALL_LIMIT = 250;
  localparam int HOLD_LIMIT = 50;
  localparam int CNT_W      = 8;
  localparam int TOT_W      = 16;
  localparam int TOT2_W     = 2;
  localparam int RTY_W      = 2;
  localparam int VW         = 3 + 5 + 2 + RTY_W + CNT_W + TOT_W + 3 + TOT2_W;

  // Spec state encodings used by the model.
  localparam int ST_IDLE = 0, ST_DIAL = 1, ST_DTO = 2, ST_CALL = 3;
  localparam int ST_END  = 4, ST_CTO  = 5, ST_HOLD = 6;

  logic clk = 1'b0;
  logic reset, valid_cntct, dial, pickup_call, cancel, end_call, hold_req, resume_req;

  logic [2:0]       state, state2;
  logic             dial_timeout, in_call, on_hold, call_timeout, call_done;
  logic             dial_timeout2, in_call2, on_hold2, call_timeout2, call_done2;
  logic [1:0]       end_cause, end_cause2;
  logic [RTY_W-1:0] retry_cnt, retry_cnt2;
  logic [CNT_W-1:0] call_time, call_time2;
  logic [TOT_W-1:0] calls_completed;
  logic [TOT2_W-1:0] calls_completed2;

  tele_call_ctrl dut (
    .clk(clk), .reset(reset), .valid_cntct(valid_cntct), .dial(dial),
    .pickup_call(pickup_call), .cancel(cancel), .end_call(end_call),
    .hold_req(hold_req), .resume_req(resume_req), .state(state),
    .dial_timeout(dial_timeout), .in_call(in_call), .on_hold(on_hold),
    .call_timeout(call_timeout), .call_done(call_done), .end_cause(end_cause),
    .retry_cnt(retry_cnt), .call_time(call_time), .calls_completed(calls_completed)
  );

  tele_call_ctrl #(.TOT_W(TOT2_W)) dut2 (
    .clk(clk), .reset(reset), .valid_cntct(valid_cntct), .dial(dial),
    .pickup_call(pickup_call), .cancel(cancel), .end_call(end_call),
    .hold_req(hold_req), .resume_req(resume_req), .state(state2),
    .dial_timeout(dial_timeout2), .in_call(in_call2), .on_hold(on_hold2),
    .call_timeout(call_timeout2), .call_done(call_done2), .end_cause(end_cause2),
    .retry_cnt(retry_cnt2), .call_time(call_time2), .calls_completed(calls_completed2)
  );

  // Clock and initial input levels.
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [VW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: elapsed time per phase, not per-register counters.
  int m_st, m_dial_el, m_retry, m_call_t, m_hold_el, m_cause, m_total, m_total2;

  task automatic model_idle();
    m_st     = ST_IDLE;
    m_retry  = 0;
    m_call_t = 0;
  endtask

  task automatic model_step(input bit r, vc, d, pk, cn, ec, hr, rs);
    m_cause = 0;
    if (r) begin
      model_idle();
      m_dial_el = 0; m_hold_el = 0; m_total = 0; m_total2 = 0;
    end else begin
      case (m_st)
        ST_IDLE: if (d && vc) begin
          m_st = ST_DIAL; m_dial_el = 0; m_retry = 0; m_call_t = 0;
        end
        ST_DIAL: begin
          if (cn) model_idle();
          else if (pk) begin m_st = ST_CALL; m_call_t = 0; end
          else begin
            m_dial_el++;
            if (m_dial_el == (MAX_RETRY + 1) * DIAL_LIMIT) m_st = ST_DTO;
            else m_retry = m_dial_el / DIAL_LIMIT;
          end
        end
        ST_DTO, ST_CTO: if (cn) model_idle();
        ST_CALL: begin
          m_call_t++;
          if (ec) begin m_st = ST_END; m_cause = 1; end
          else if (hr) begin m_st = ST_HOLD; m_hold_el = 0; end
          else if (m_call_t == CALL_LIMIT) m_st = ST_CTO;
        end
        ST_HOLD: begin
          if (ec) begin m_st = ST_END; m_cause = 1; end
          else if (rs) m_st = ST_CALL;
          else begin
            m_hold_el++;
            if (m_hold_el == HOLD_LIMIT) begin m_st = ST_END; m_cause = 2; end
          end
        end
        ST_END: begin
          if (m_total < (1 << TOT_W) - 1) m_total++;
          if (m_total2 < (1 << TOT2_W) - 1) m_total2++;
          model_idle();
        end
        default: model_idle();
      endcase
    end
  endtask

  function automatic logic [VW-1:0] model_outputs();
    logic [2:0] st;
    st = 3'(m_st);
    return {st, (m_st == ST_DTO), (m_st == ST_CALL), (m_st == ST_HOLD),
            (m_st == ST_CTO), (m_st == ST_END), 2'(m_cause), RTY_W'(m_retry),
            CNT_W'(m_call_t), TOT_W'(m_total), st, TOT2_W'(m_total2)};
  endfunction

  // Driver: apply one cycle of inputs after the edge, predict the next edge.
  task automatic drive(input bit r, vc, d, pk, cn, ec, hr, rs);
    @(posedge clk);
    #2;
    reset = r; valid_cntct = vc; dial = d; pickup_call = pk;
    cancel = cn; end_call = ec; hold_req = hr; resume_req = rs;
    model_step(r, vc, d, pk, cn, ec, hr, rs);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_dial();   drive(0, 1, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_pickup(); drive(0, 1, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_cancel(); drive(0, 1, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_end();    drive(0, 1, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_hold();   drive(0, 1, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_resume(); drive(0, 1, 0, 0, 0, 0, 0, 1); endtask

  // Monitor: one comparison per cycle, just after the active edge.
  initial begin
    logic [VW-1:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, dial_timeout, in_call, on_hold, call_timeout, call_done,
               end_cause, retry_cnt, call_time, calls_completed, state2, calls_completed2};
        n_vec++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %h required %h (state %0d/%0d time %0d/%0d retry %0d/%0d)",
                   cyc, got, exp, state, exp[VW-1 -: 3], call_time,
                   exp[TOT_W+3+TOT2_W +: CNT_W], retry_cnt,
                   exp[CNT_W+TOT_W+3+TOT2_W +: RTY_W]);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    reset = 1'b1; valid_cntct = 1'b0; dial = 1'b0; pickup_call = 1'b0;
    cancel = 1'b0; end_call = 1'b0; hold_req = 1'b0; resume_req = 1'b0;

    // Reset, dial without a valid contact, then answered on 3rd DIAL cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    do_dial(); idle(2); do_pickup(); idle(3);
    do_end(); idle(2);

    // Unanswered: two redials then dial timeout; inputs other than cancel ignored.
    do_dial(); idle(17);
    do_end(); do_pickup(); do_cancel(); idle(2);

    // Cancel while dialling.
    do_dial(); idle(3); do_cancel(); idle(1);

    // Hold and resume, then local hang-up.
    do_dial(); do_pickup(); idle(10); do_hold(); idle(20);
    do_resume(); idle(5); do_end(); idle(2);

    // Call timeout, not counted; cancel returns to IDLE.
    do_dial(); do_pickup(); idle(255); do_end(); do_cancel(); idle(2);

    // Hold expiry.
    do_dial(); do_pickup(); do_hold(); idle(55);

    // end_call, hold_req and call limit all together: hang-up wins.
    do_dial(); do_pickup(); idle(249); drive(0, 1, 0, 0, 0, 1, 1, 0); idle(2);

    // Reset in the middle of HOLD.
    do_dial(); do_pickup(); do_hold(); idle(5);
    drive(1, 1, 0, 0, 0, 0, 1, 0); idle(2);

    // Five completed calls: the narrow counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      do_dial(); do_pickup(); do_end(); idle(1);
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
    end

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
